pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-low (rst=0 resets immediately, independent of clk).
REQ-003 SHALL have port stallreq_from_id  in  1  ID stage hazard stall request.
REQ-004 SHALL have port stallreq_from_ex  in  1  EX stage multi-cycle stall request.
REQ-005 SHALL have port stallreq_from_mem  in  1  MEM stage bus-wait stall request.
REQ-006 SHALL have port excepttype_i  in  32  exception code from MEM stage; 0 = none.
REQ-007 SHALL have port cp0_epc_i  in  32  EPC value used for eret.
REQ-008 SHALL have port stall  out  6  per-stage stall; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = Stop.
REQ-009 SHALL have port flush  out  1  pipeline flush to all stage registers.
REQ-010 SHALL have port new_pc  out  32  redirect target, valid only while flush=1.
REQ-011 SHALL have port stall_cnt_o  out  32  saturating count of cycles with stall!=0.
REQ-012 SHALL have port except_cnt_o  out  16  saturating count of accepted exceptions.
REQ-013 SHALL have port last_excepttype_o  out  32  code of most recently accepted exception.
REQ-014 SHALL have port stall_timeout_o  out  1  sticky watchdog flag.
REQ-015 SHALL have parameter EXC_VECTOR, default 32'h00000020, exception handler address.
REQ-016 SHALL have parameter STALL_LIMIT, default 255, continuous-stall watchdog threshold (cycles).

Function
REQ-017 stall, flush, new_pc SHALL be combinational from inputs and FSM state (zero-cycle latency).
REQ-018 Stall priority, absent exception: mem -> 6'b011111; else ex -> 6'b001111; else id -> 6'b000111; else 6'b000000.
REQ-019 FSM states: IDLE, FLUSH_HOLD; reset state IDLE.
REQ-020 In IDLE, excepttype_i!=0 SHALL be accepted: flush=1, stall=0 regardless of any stallreq, next state FLUSH_HOLD.
REQ-021 new_pc SHALL be cp0_epc_i when excepttype_i==32'h0000000e (eret), else EXC_VECTOR; 0 when flush=0.
REQ-022 In FLUSH_HOLD (exactly one cycle): flush=0, stall=0, excepttype_i ignored, stallreqs ignored; next state IDLE.
REQ-023 On acceptance, last_excepttype_o SHALL load excepttype_i and except_cnt_o SHALL increment, saturating at 16'hFFFF.
REQ-024 stall_cnt_o SHALL increment each cycle stall!=0, saturating at 32'hFFFFFFFF.
REQ-025 Internal run counter SHALL count consecutive cycles with stall!=0, clear on any cycle with stall==0 or flush=1, and saturate at STALL_LIMIT.
REQ-026 stall_timeout_o SHALL set on the edge where run counter reaches STALL_LIMIT and remain 1 until reset.
REQ-027 Exception in the same cycle as any stallreq SHALL win; that cycle SHALL NOT count toward stall_cnt_o.
REQ-028 Back-to-back exception codes on consecutive cycles: first accepted, second dropped (FLUSH_HOLD); third cycle accepted if still present.

Reset
REQ-029 On rst=0: state IDLE; stall_cnt_o=0, except_cnt_o=0, last_excepttype_o=0, stall_timeout_o=0, run counter=0.
REQ-030 While rst=0: stall=0, flush=0, new_pc=0, regardless of inputs.
REQ-031 Reset asserted mid-FLUSH_HOLD or mid-stall SHALL abort immediately; first cycle after release is IDLE with all counters 0.

Verification
REQ-032 stallreq_from_id=1, ex=1 together for 3 cycles -> stall=6'b001111 each cycle; stall_cnt_o=3 afterwards.
REQ-033 excepttype_i=32'h00000008 with stallreq_from_mem=1 -> same cycle flush=1, stall=0, new_pc=32'h20; next cycle flush=0; except_cnt_o=1, last_excepttype_o=8.
REQ-034 excepttype_i=32'h0000000e, cp0_epc_i=32'h00400100 -> flush=1, new_pc=32'h00400100.
REQ-035 excepttype_i=32'h0000000c held 3 cycles -> flush=1,0,1; except_cnt_o=2.
REQ-036 STALL_LIMIT=4, stallreq_from_ex held 4 cycles -> stall_timeout_o=1 after 4th edge; stays 1 after stall drops; clears only on rst=0.
REQ-037 rst driven 0 asynchronously between clock edges during stall -> stall=0 and counters=0 immediately, before next edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall vector, exception flush and
// redirect, plus stall/exception statistics and a continuous-stall watchdog.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt_o,
    output logic [15:0] except_cnt_o,
    output logic [31:0] last_excepttype_o,
    output logic        stall_timeout_o
);

    localparam logic [31:0] ERET_CODE = 32'h0000_000e;

    typedef enum logic {
        IDLE,
        FLUSH_HOLD
    } state_t;

    state_t      state;
    logic [31:0] run_cnt;
    logic [31:0] run_nxt;
    logic        accept;
    logic        stall_any;

    // An exception is taken only in IDLE; the hold cycle after a flush swallows
    // whatever code is still on the input so one fault is not taken twice.
    assign accept    = rst && (state == IDLE) && (excepttype_i != 32'h0);
    assign stall_any = (stall != 6'b000000);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = 32'h0;
        if (accept) begin
            flush  = 1'b1;
            new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        end else if (rst && state == IDLE) begin
            if (stallreq_from_mem)     stall = 6'b011111;
            else if (stallreq_from_ex) stall = 6'b001111;
            else if (stallreq_from_id) stall = 6'b000111;
        end
    end

    always_comb begin
        run_nxt = 32'h0;
        if (stall_any)
            run_nxt = (run_cnt < STALL_LIMIT) ? run_cnt + 32'd1 : run_cnt;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            run_cnt           <= 32'h0;
            stall_cnt_o       <= 32'h0;
            except_cnt_o      <= 16'h0;
            last_excepttype_o <= 32'h0;
            stall_timeout_o   <= 1'b0;
        end else begin
            state   <= accept ? FLUSH_HOLD : IDLE;
            run_cnt <= run_nxt;
            if (stall_any && stall_cnt_o != 32'hFFFF_FFFF)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (accept) begin
                last_excepttype_o <= excepttype_i;
                if (except_cnt_o != 16'hFFFF)
                    except_cnt_o <= except_cnt_o + 16'd1;
            end
            if (stall_any && run_nxt == STALL_LIMIT)
                stall_timeout_o <= 1'b1;
        end
    end

endmodule
